spi_target_regfile: RTL

SPI target (slave) register file: the responder end of the SPI command link driven by the command handler. It receives 16-bit frames (one R/W bit, a 7-bit address and an 8-bit data byte, MSB first) on an externally clocked SPI bus and oversamples that bus with the system clock. It applies writes to an internal register bank and returns register contents on reads. It sits on the peripheral side of the link and exposes the register bank to local logic.

---
 rtl/spi_target_regfile_if.sv | 11 +
 rtl/spi_target_regfile.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/spi_target_regfile_if.sv
// SPI bus between the command-link initiator and the register-file target.
interface spi_target_regfile_if;
    logic sclk;
    logic csb;
    logic sdi;
    logic sdo;
    logic sdo_oe;

    modport master (output sclk, output csb, output sdi, input sdo, input sdo_oe);
    modport slave  (input sclk, input csb, input sdi, output sdo, output sdo_oe);
endinterface

// File: rtl/spi_target_regfile.sv
// SPI mode-0 target with an oversampled bus front end and a small register bank.
// Frames are {rw, addr[6:0], data[7:0]} MSB first; rw=1 writes.
module spi_target_regfile #(
    parameter int PACKAGE_SIZE = 8,
    parameter int NUM_REGS     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_target_regfile_if.slave     spi,
    input  logic [PACKAGE_SIZE-2:0] host_addr,
    output logic [PACKAGE_SIZE-1:0] host_rdata,
    output logic                    wr_strobe,
    output logic [PACKAGE_SIZE-2:0] wr_addr,
    output logic [PACKAGE_SIZE-1:0] wr_data,
    output logic                    frame_err
);
    localparam int AW = PACKAGE_SIZE - 1;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_WAIT} state_t;

    logic [1:0]              sclk_sync_q, csb_sync_q, sdi_sync_q;
    logic                    sclk_prev_q, csb_q;
    state_t                  state_q;
    logic [4:0]              cnt_q;
    logic [AW-1:0]           hdr_q, addr_q;
    logic [PACKAGE_SIZE-1:0] dat_q, rd_sh_q;
    logic                    rw_q, sdo_q;
    logic                    wr_strobe_q, frame_err_q;
    logic [AW-1:0]           wr_addr_q;
    logic [PACKAGE_SIZE-1:0] wr_data_q;
    logic [PACKAGE_SIZE-1:0] regs_q [NUM_REGS];

    logic                    rise_d, fall_d;
    logic [PACKAGE_SIZE-1:0] hdr_full_d, rd_lookup_d;

    assign rise_d     = sclk_sync_q[1] & ~sclk_prev_q;
    assign fall_d     = ~sclk_sync_q[1] & sclk_prev_q;
    assign hdr_full_d = {hdr_q, sdi_sync_q[1]};

    always_comb begin
        rd_lookup_d = '0;
        if (int'(hdr_full_d[AW-1:0]) < NUM_REGS) rd_lookup_d = regs_q[hdr_full_d[IW-1:0]];
    end

    always_comb begin
        host_rdata = '0;
        if (int'(host_addr) < NUM_REGS) host_rdata = regs_q[host_addr[IW-1:0]];
    end

    // csb_q is one stage behind csb_sync_q so the FSM sees csb as a registered edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            csb_sync_q  <= '1;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            csb_q       <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi.sclk};
            csb_sync_q  <= {csb_sync_q[0], spi.csb};
            sdi_sync_q  <= {sdi_sync_q[0], spi.sdi};
            sclk_prev_q <= sclk_sync_q[1];
            csb_q       <= csb_sync_q[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hdr_q       <= '0;
            addr_q      <= '0;
            dat_q       <= '0;
            rd_sh_q     <= '0;
            rw_q        <= 1'b0;
            sdo_q       <= 1'b0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sdo_q <= 1'b0;
                    if (!csb_q) begin
                        state_q <= S_HDR;
                        cnt_q   <= '0;
                        hdr_q   <= '0;
                        dat_q   <= '0;
                    end
                end
                S_HDR: begin
                    if (csb_q) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (rise_d) begin
                        hdr_q <= hdr_full_d[AW-1:0];
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'(PACKAGE_SIZE - 1)) begin
                            rw_q    <= hdr_full_d[PACKAGE_SIZE-1];
                            addr_q  <= hdr_full_d[AW-1:0];
                            rd_sh_q <= hdr_full_d[PACKAGE_SIZE-1] ? '0 : rd_lookup_d;
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (csb_q) begin
                        frame_err_q <= 1'b1;
                        sdo_q       <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        if (fall_d && !rw_q) begin
                            sdo_q   <= rd_sh_q[PACKAGE_SIZE-1];
                            rd_sh_q <= {rd_sh_q[PACKAGE_SIZE-2:0], 1'b0};
                        end
                        if (rise_d) begin
                            cnt_q <= cnt_q + 5'd1;
                            if (rw_q) dat_q <= {dat_q[PACKAGE_SIZE-2:0], sdi_sync_q[1]};
                            if (cnt_q == 5'(2 * PACKAGE_SIZE - 1)) state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    sdo_q <= 1'b0;
                    if (rw_q && int'(addr_q) < NUM_REGS) begin
                        regs_q[addr_q[IW-1:0]] <= dat_q;
                        wr_strobe_q            <= 1'b1;
                        wr_addr_q              <= addr_q;
                        wr_data_q              <= dat_q;
                    end
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    sdo_q <= 1'b0;
                    if (csb_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign spi.sdo    = sdo_q;
    assign spi.sdo_oe = ~csb_sync_q[1];
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_err  = frame_err_q;
endmodule
